// File: rtl/at93c46d_responder_if.sv
// Microwire bus between an EEPROM master and the AT93C46D responder.
// The master drives cs/sclk/din; the responder drives dout and its output enable.
interface at93c46d_responder_if;
    logic cs;
    logic sclk;
    logic din;
    logic dout;
    logic dout_oe;

    modport master (output cs, sclk, din, input dout, dout_oe);
    modport slave  (input cs, sclk, din, output dout, dout_oe);
endinterface

// File: rtl/at93c46d_responder.sv
// AT93C46D (x16, 64 words) Microwire responder: oversamples the serial bus on clk,
// serves READ data and runs self-timed write/erase cycles into an internal array.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start bit; drives ready/busy status when pending
// S_OPCODE | shifting in the 2 opcode bits
// S_ADDR   | shifting in the address bits, decode on the last one
// S_READ   | shifting array word out on dout, MSB first
// S_DATA   | shifting in the write data word (WRITE / WRAL)
// S_ARMED  | write-class instruction complete, waiting for cs to fall
// S_DONE   | instruction finished; further sclk rises drive 0
module at93c46d_responder #(
    parameter int                    ADDR_WIDTH   = 6,
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    WRITE_CYCLES = 1000,
    parameter logic [DATA_WIDTH-1:0] INIT_WORD    = 16'hFFFF
) (
    input  logic                       clk,
    input  logic                       rst,
    at93c46d_responder_if.slave        bus,
    output logic                       busy,
    output logic                       wr_en
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = $clog2((DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH) + 1;
    localparam int TMR_W = $clog2(WRITE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_OPCODE, S_ADDR, S_READ, S_DATA, S_ARMED, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        PK_WRITE, PK_WRAL, PK_ERASE, PK_ERAL
    } prog_t;

    state_t                 state;
    prog_t                  prog_kind;
    logic                   cs_s1, cs_s2, cs_q;
    logic                   sclk_s1, sclk_s2, sclk_q;
    logic                   din_s1, din_s2;
    logic [CNT_W-1:0]       bit_cnt;
    logic [1:0]             opcode;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0]  shreg;
    logic [TMR_W-1:0]       busy_cnt;
    logic                   status_pend;
    logic                   dout_r;
    logic                   dout_oe_r;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    logic                   sclk_rise;
    logic                   cs_fall;
    logic                   busy_nxt;
    logic [ADDR_WIDTH-1:0]  addr_nxt;

    assign sclk_rise = sclk_s2 & ~sclk_q;
    assign cs_fall   = ~cs_s2 & cs_q;
    assign addr_nxt  = {addr[ADDR_WIDTH-2:0], din_s2};
    // busy as it will be after this edge, so the status bit never lags busy
    assign busy_nxt  = busy && (busy_cnt != TMR_W'(1));

    assign bus.dout    = dout_r;
    assign bus.dout_oe = dout_oe_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_s1       <= 1'b0;
            cs_s2       <= 1'b0;
            cs_q        <= 1'b0;
            sclk_s1     <= 1'b0;
            sclk_s2     <= 1'b0;
            sclk_q      <= 1'b0;
            din_s1      <= 1'b0;
            din_s2      <= 1'b0;
            state       <= S_IDLE;
            prog_kind   <= PK_WRITE;
            bit_cnt     <= '0;
            opcode      <= '0;
            addr        <= '0;
            shreg       <= '0;
            busy        <= 1'b0;
            busy_cnt    <= '0;
            wr_en       <= 1'b0;
            status_pend <= 1'b0;
            dout_r      <= 1'b0;
            dout_oe_r   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_WORD;
        end else begin
            cs_s1   <= bus.cs;
            cs_s2   <= cs_s1;
            cs_q    <= cs_s2;
            sclk_s1 <= bus.sclk;
            sclk_s2 <= sclk_s1;
            sclk_q  <= sclk_s2;
            din_s1  <= bus.din;
            din_s2  <= din_s1;

            if (busy) begin
                busy_cnt <= busy_cnt - TMR_W'(1);
                busy     <= busy_nxt;
            end

            if (!cs_s2) begin
                state     <= S_IDLE;
                bit_cnt   <= '0;
                dout_r    <= 1'b0;
                dout_oe_r <= 1'b0;
                // Array contents change on the same clk that busy rises.
                if (cs_fall && state == S_ARMED && wr_en && !busy) begin
                    busy        <= 1'b1;
                    busy_cnt    <= TMR_W'(WRITE_CYCLES);
                    status_pend <= 1'b1;
                    case (prog_kind)
                        PK_WRITE: mem[addr] <= shreg;
                        PK_ERASE: mem[addr] <= INIT_WORD;
                        PK_WRAL:  for (int i = 0; i < DEPTH; i++) mem[i] <= shreg;
                        default:  for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_WORD;
                    endcase
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (sclk_rise && din_s2) begin
                            state       <= S_OPCODE;
                            bit_cnt     <= '0;
                            status_pend <= 1'b0;
                            dout_r      <= 1'b0;
                            dout_oe_r   <= 1'b0;
                        end else if (status_pend) begin
                            dout_oe_r <= 1'b1;
                            dout_r    <= ~busy_nxt;
                        end
                    end
                    S_OPCODE: begin
                        if (sclk_rise) begin
                            opcode <= {opcode[0], din_s2};
                            if (bit_cnt == CNT_W'(1)) begin
                                state   <= S_ADDR;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    S_ADDR: begin
                        if (sclk_rise) begin
                            addr <= addr_nxt;
                            if (bit_cnt == LAST_ADDR) begin
                                bit_cnt <= '0;
                                case (opcode)
                                    2'b10: begin
                                        state     <= S_READ;
                                        dout_oe_r <= 1'b1;
                                        dout_r    <= 1'b0;
                                        shreg     <= mem[addr_nxt];
                                    end
                                    2'b01: begin
                                        state     <= S_DATA;
                                        prog_kind <= PK_WRITE;
                                    end
                                    2'b11: begin
                                        state     <= S_ARMED;
                                        prog_kind <= PK_ERASE;
                                    end
                                    default: begin
                                        case (addr_nxt[ADDR_WIDTH-1 -: 2])
                                            2'b01: begin
                                                state     <= S_DATA;
                                                prog_kind <= PK_WRAL;
                                            end
                                            2'b10: begin
                                                state     <= S_ARMED;
                                                prog_kind <= PK_ERAL;
                                            end
                                            2'b11: begin
                                                state <= S_DONE;
                                                wr_en <= 1'b1;
                                            end
                                            default: begin
                                                state <= S_DONE;
                                                wr_en <= 1'b0;
                                            end
                                        endcase
                                    end
                                endcase
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    S_READ: begin
                        if (sclk_rise) begin
                            dout_r <= shreg[DATA_WIDTH-1];
                            shreg  <= {shreg[DATA_WIDTH-2:0], 1'b0};
                            if (bit_cnt == LAST_DATA) begin
                                state   <= S_DONE;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    S_DATA: begin
                        if (sclk_rise) begin
                            shreg <= {shreg[DATA_WIDTH-2:0], din_s2};
                            if (bit_cnt == LAST_DATA) begin
                                state   <= S_ARMED;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    S_DONE: begin
                        if (sclk_rise) dout_r <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_at93c46d_responder.sv
// Self-checking bench for at93c46d_responder: drives Microwire instructions and
// scores READ data against a reference copy of the array.
module tb_at93c46d_responder;
    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic wr_en;

    at93c46d_responder_if bus();

    at93c46d_responder #(.WRITE_CYCLES(1000)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .busy  (busy),
        .wr_en (wr_en)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] mdl [64];
    logic [15:0] sb_q [$];
    string       sb_tag [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one sclk period: din set in low phase, dout sampled just before the falling edge
    task automatic clock_bit(input logic b, output logic s);
        bus.din = b;
        #30;
        bus.sclk = 1'b1;
        #60;
        s = bus.dout;
        bus.sclk = 1'b0;
        #30;
    endtask

    task automatic shift_out(input logic [31:0] v, input int n);
        logic s;
        for (int i = n - 1; i >= 0; i--) clock_bit(v[i], s);
    endtask

    // leaves cs low on return so busy timing can be measured from the cs fall
    task automatic send_instr(input logic [1:0] op, input logic [5:0] a,
                              input logic [15:0] d, input int ndata);
        logic [31:0] dv;
        #60;
        bus.cs = 1'b1;
        #60;
        shift_out({23'd0, 1'b1, op, a}, 9);
        if (ndata > 0) begin
            dv = {16'd0, d} >> (16 - ndata);
            shift_out(dv, ndata);
        end
        #60;
        bus.cs = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [5:0] a);
        logic        s;
        logic [15:0] w;
        logic [15:0] exp;
        string       t;
        sb_q.push_back(mdl[a]);
        sb_tag.push_back(tag);
        w = '0;
        #60;
        bus.cs = 1'b1;
        #60;
        shift_out({24'd0, 3'b110, a[5:1]}, 8);
        clock_bit(a[0], s);
        check_eq({tag, "_dummy"}, {31'd0, s}, 32'd0);
        check_eq({tag, "_oe"}, {31'd0, bus.dout_oe}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            clock_bit(1'b0, s);
            w = {w[14:0], s};
        end
        #60;
        bus.cs = 1'b0;
        exp = sb_q.pop_front();
        t = sb_tag.pop_front();
        check_eq(t, {16'd0, w}, {16'd0, exp});
    endtask

    task automatic measure_busy(output int n);
        int w;
        w = 0;
        n = 0;
        while (!busy && w < 10) begin
            @(posedge clk);
            #1;
            w++;
        end
        while (busy && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic wait_not_busy();
        for (int i = 0; i < 1500 && busy; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int n_busy;

    initial begin
        bus.cs   = 1'b0;
        bus.sclk = 1'b0;
        bus.din  = 1'b0;
        rst      = 1'b1;
        for (int i = 0; i < 64; i++) mdl[i] = 16'hFFFF;
        #10;
        check_eq("rst_dout",    {31'd0, bus.dout},    32'd0);
        check_eq("rst_dout_oe", {31'd0, bus.dout_oe}, 32'd0);
        check_eq("rst_busy",    {31'd0, busy},        32'd0);
        check_eq("rst_wr_en",   {31'd0, wr_en},       32'd0);
        #10;
        rst = 1'b0;

        do_read("rd_init_05", 6'h05);
        check_eq("wr_en_after_rst", {31'd0, wr_en}, 32'd0);

        // EWEN then WRITE 0x05
        send_instr(2'b00, 6'h30, 16'h0, 0);
        #60;
        check_eq("ewen", {31'd0, wr_en}, 32'd1);
        send_instr(2'b01, 6'h05, 16'hA5C3, 16);
        mdl[5] = 16'hA5C3;
        measure_busy(n_busy);
        check_eq("write_busy_len", n_busy, 32'd1000);
        do_read("rd_05_a5c3", 6'h05);
        do_read("rd_06_ffff", 6'h06);

        // EWDS blocks writes
        send_instr(2'b00, 6'h00, 16'h0, 0);
        #60;
        check_eq("ewds", {31'd0, wr_en}, 32'd0);
        send_instr(2'b01, 6'h05, 16'h1234, 16);
        #300;
        check_eq("ewds_no_busy", {31'd0, busy}, 32'd0);
        do_read("rd_05_protect", 6'h05);

        // WRAL, ERASE, ERAL
        send_instr(2'b00, 6'h30, 16'h0, 0);
        send_instr(2'b00, 6'h10, 16'h0F0F, 16);
        for (int i = 0; i < 64; i++) mdl[i] = 16'h0F0F;
        measure_busy(n_busy);
        check_eq("wral_busy_len", n_busy, 32'd1000);
        send_instr(2'b11, 6'h3F, 16'h0, 0);
        mdl[63] = 16'hFFFF;
        measure_busy(n_busy);
        check_eq("erase_busy_len", n_busy, 32'd1000);
        do_read("rd_00_wral", 6'h00);
        do_read("rd_3f_erase", 6'h3F);
        do_read("rd_05_wral", 6'h05);
        send_instr(2'b00, 6'h20, 16'h0, 0);
        for (int i = 0; i < 64; i++) mdl[i] = 16'hFFFF;
        measure_busy(n_busy);
        check_eq("eral_busy_len", n_busy, 32'd1000);
        do_read("rd_00_eral", 6'h00);
        do_read("rd_15_eral", 6'h15);
        do_read("rd_3f_eral", 6'h3F);

        // cs dropped after 10 data bits
        send_instr(2'b01, 6'h10, 16'hBEEF, 10);
        #300;
        check_eq("partial_no_busy", {31'd0, busy}, 32'd0);
        do_read("rd_10_partial", 6'h10);

        // ready/busy status on re-raised cs
        send_instr(2'b01, 6'h07, 16'h55AA, 16);
        mdl[7] = 16'h55AA;
        #200;
        bus.cs = 1'b1;
        #50;
        check_eq("status_busy",    {31'd0, busy},        32'd1);
        check_eq("status_oe_busy", {31'd0, bus.dout_oe}, 32'd1);
        check_eq("status_dout_0",  {31'd0, bus.dout},    32'd0);
        wait_not_busy();
        check_eq("busy_clear", {31'd0, busy}, 32'd0);
        #30;
        check_eq("status_oe_ready", {31'd0, bus.dout_oe}, 32'd1);
        check_eq("status_dout_1",   {31'd0, bus.dout},    32'd1);
        bus.cs = 1'b0;
        #60;
        check_eq("status_off_cs_low", {31'd0, bus.dout_oe}, 32'd0);
        do_read("rd_07_55aa", 6'h07);

        // async reset mid-program
        send_instr(2'b01, 6'h08, 16'h1111, 16);
        #500;
        check_eq("prog_busy_pre_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #20;
        check_eq("rst_mid_busy",  {31'd0, busy},  32'd0);
        check_eq("rst_mid_wr_en", {31'd0, wr_en}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) mdl[i] = 16'hFFFF;
        do_read("rd_08_after_rst", 6'h08);
        do_read("rd_07_after_rst", 6'h07);

        check_eq("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
